// File: rtl/step_counter.sv
// Purpose : up/down counter with a per-cycle step, synchronous load, and wrap or clamp on overflow.
// Latency : count/cout register the inputs sampled at each rising edge; zero/at_max decode count combinationally.
// Backpress: none; there is no handshake, so every enabled cycle applies exactly one step.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - asynchronous active-high reset (count=0, cout=0)
//   en       - count enable, one step per enabled cycle
//   up       - 1 adds step, 0 subtracts step
//   step     - unsigned step magnitude (WIDTH bits)
//   load     - synchronous load request, wins over en
//   load_val - value written on load
//   count    - registered counter value
//   cout     - registered one-cycle overflow/underflow (or clamp) pulse
//   zero     - high while count == 0
//   at_max   - high while count == 2^WIDTH-1
module step_counter #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             cout,
  output logic             zero,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // One extra bit on top of the count: after an add it holds the carry,
  // after a subtract it holds the borrow (the difference went negative).
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] next_count;
  logic             next_cout;

  always_comb begin
    sum = '0;
    if (up) begin
      sum = {1'b0, count} + {1'b0, step};
    end else begin
      sum = {1'b0, count} - {1'b0, step};
    end
  end

  assign carry = sum[WIDTH];

  // Result of one enabled step. In clamp mode an out-of-range result pins
  // to the limit in the direction of travel; a step of 0 never carries, so
  // it falls through to the unchanged low bits with no pulse.
  always_comb begin
    step_val = sum[WIDTH-1:0];
    if (SATURATE != 0 && carry) begin
      step_val = up ? MAX_VAL : '0;
    end
  end

  // Priority: load over en over hold. cout is recomputed every edge so it
  // can never stay high without a fresh overflow.
  always_comb begin
    next_count = count;
    next_cout  = 1'b0;
    if (load) begin
      next_count = load_val;
      next_cout  = 1'b0;
    end else if (en) begin
      next_count = step_val;
      next_cout  = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      cout  <= 1'b0;
    end else begin
      count <= next_count;
      cout  <= next_cout;
    end
  end

  assign zero   = (count == '0);
  assign at_max = (count == MAX_VAL);

endmodule

// File: tb/tb_step_counter.sv
// Purpose : checks step_counter (WIDTH=4) in wrap mode and clamp mode with directed vectors.
// Latency : drivers queue the expected count/cout for each edge; a monitor compares 1 time unit after that edge.
// Backpress: none; every queued expectation is consumed by the edge that follows it.
module tb_step_counter;

  typedef struct packed {
    logic [3:0] count;
    logic       cout;
  } exp_t;

  logic clk;

  // wrap-mode instance
  logic       rst_w, en_w, up_w, load_w;
  logic [3:0] step_w, load_val_w, count_w;
  logic       cout_w, zero_w, at_max_w;

  // clamp-mode instance
  logic       rst_s, en_s, up_s, load_s;
  logic [3:0] step_s, load_val_s, count_s;
  logic       cout_s, zero_s, at_max_s;

  exp_t q_w[$];
  exp_t q_s[$];

  int n_checks = 0;
  int n_fail   = 0;
  int vec_w    = 0;
  int vec_s    = 0;

  step_counter #(.WIDTH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst_w), .en(en_w), .up(up_w), .step(step_w),
    .load(load_w), .load_val(load_val_w),
    .count(count_w), .cout(cout_w), .zero(zero_w), .at_max(at_max_w)
  );

  step_counter #(.WIDTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst_s), .en(en_s), .up(up_s), .step(step_s),
    .load(load_s), .load_val(load_val_s),
    .count(count_s), .cout(cout_s), .zero(zero_s), .at_max(at_max_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0d, expected %0d", name, idx, act, req);
    end
  endtask

  // Monitor: one edge consumes at most one expectation per instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        vec_w++;
        chk("wrap count",  vec_w, int'(count_w),  int'(e.count));
        chk("wrap cout",   vec_w, int'(cout_w),   int'(e.cout));
        chk("wrap zero",   vec_w, int'(zero_w),   int'(e.count == 4'd0));
        chk("wrap at_max", vec_w, int'(at_max_w), int'(e.count == 4'd15));
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        vec_s++;
        chk("sat count",  vec_s, int'(count_s),  int'(e.count));
        chk("sat cout",   vec_s, int'(cout_s),   int'(e.cout));
        chk("sat zero",   vec_s, int'(zero_s),   int'(e.count == 4'd0));
        chk("sat at_max", vec_s, int'(at_max_s), int'(e.count == 4'd15));
      end
    end
  end

  task automatic drv_w(input logic ld, input logic [3:0] lv, input logic e, input logic u,
                       input logic [3:0] st, input logic [3:0] ec, input logic eco);
    exp_t x;
    @(negedge clk);
    load_w = ld; load_val_w = lv; en_w = e; up_w = u; step_w = st;
    x.count = ec;
    x.cout  = eco;
    q_w.push_back(x);
    @(posedge clk);
  endtask

  task automatic drv_s(input logic ld, input logic [3:0] lv, input logic e, input logic u,
                       input logic [3:0] st, input logic [3:0] ec, input logic eco);
    exp_t x;
    @(negedge clk);
    load_s = ld; load_val_s = lv; en_s = e; up_s = u; step_s = st;
    x.count = ec;
    x.cout  = eco;
    q_s.push_back(x);
    @(posedge clk);
  endtask

  task automatic idle_w();
    @(negedge clk);
    load_w = 1'b0; en_w = 1'b0;
  endtask

  task automatic idle_s();
    @(negedge clk);
    load_s = 1'b0; en_s = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with load/en active: both must be ignored.
    rst_w = 1'b1; rst_s = 1'b1;
    load_w = 1'b1; load_val_w = 4'd5; en_w = 1'b1; up_w = 1'b1; step_w = 4'd3;
    load_s = 1'b1; load_val_s = 4'd5; en_s = 1'b1; up_s = 1'b1; step_s = 4'd3;
    #22;
    chk("reset count",  0, int'(count_w),  0);
    chk("reset cout",   0, int'(cout_w),   0);
    chk("reset zero",   0, int'(zero_w),   1);
    chk("reset at_max", 0, int'(at_max_w), 0);
    chk("reset sat count", 0, int'(count_s), 0);
    chk("reset sat zero",  0, int'(zero_s),  1);

    @(negedge clk);
    load_w = 1'b0; en_w = 1'b0; load_s = 1'b0; en_s = 1'b0;
    rst_w = 1'b0; rst_s = 1'b0;

    // ---------------- wrap mode ----------------
    // 16 single steps up: 1..15 then 0 with the only cout on 15->0.
    for (int i = 1; i <= 16; i++) begin
      drv_w(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 4'(i), (i == 16));
    end
    // load 3, subtract 5 twice: 14 with borrow, then 9.
    drv_w(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 4'd3,  1'b0);
    drv_w(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 4'd14, 1'b1);
    drv_w(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 4'd9,  1'b0);
    // load beats en; then step 0 holds.
    drv_w(1'b1, 4'd9, 1'b1, 1'b1, 4'd3, 4'd9, 1'b0);
    drv_w(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b0);
    // exact landing on max, no carry; then hold.
    drv_w(1'b1, 4'd14, 1'b0, 1'b0, 4'd0, 4'd14, 1'b0);
    drv_w(1'b0, 4'd0,  1'b1, 1'b1, 4'd1, 4'd15, 1'b0);
    drv_w(1'b0, 4'd0,  1'b0, 1'b1, 4'd1, 4'd15, 1'b0);
    // down wrap 0 -> 15 with borrow; cout drops on the following hold.
    drv_w(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0,  1'b0);
    drv_w(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd15, 1'b1);
    drv_w(1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd15, 1'b0);
    // 15 + 8 -> 7 with carry, then async reset between edges.
    drv_w(1'b1, 4'd15, 1'b0, 1'b0, 4'd0, 4'd15, 1'b0);
    drv_w(1'b0, 4'd0,  1'b1, 1'b1, 4'd8, 4'd7,  1'b1);
    #3;
    rst_w = 1'b1;
    #1;
    chk("async rst count",  0, int'(count_w),  0);
    chk("async rst cout",   0, int'(cout_w),   0);
    chk("async rst zero",   0, int'(zero_w),   1);
    // load/en during reset must not take effect.
    @(negedge clk);
    load_w = 1'b1; load_val_w = 4'd9; en_w = 1'b1; up_w = 1'b1; step_w = 4'd3;
    @(posedge clk);
    #1;
    chk("rst held count", 0, int'(count_w), 0);
    chk("rst held cout",  0, int'(cout_w),  0);
    @(negedge clk);
    load_w = 1'b0; en_w = 1'b0;
    rst_w = 1'b0;
    drv_w(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0);
    idle_w();

    // ---------------- clamp mode ----------------
    // load 13, +4 three times: pinned at 15, cout every cycle.
    drv_s(1'b1, 4'd13, 1'b0, 1'b1, 4'd0, 4'd13, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drv_s(1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 4'd15, 1'b1);
    end
    // 13 + 2 lands on 15 exactly: no clamp.
    drv_s(1'b1, 4'd13, 1'b0, 1'b1, 4'd0, 4'd13, 1'b0);
    drv_s(1'b0, 4'd0,  1'b1, 1'b1, 4'd2, 4'd15, 1'b0);
    // step 0 at the limit: no pulse; step 1 at the limit: pulse.
    drv_s(1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 4'd15, 1'b0);
    drv_s(1'b0, 4'd0,  1'b1, 1'b1, 4'd1, 4'd15, 1'b1);
    // load 2, -7 clamps to 0; again at 0; then hold drops cout.
    drv_s(1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0);
    drv_s(1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 4'd0, 1'b1);
    drv_s(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1);
    drv_s(1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0);
    // in-range subtract and exact landing on 0.
    drv_s(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0);
    drv_s(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 4'd2, 1'b0);
    drv_s(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0);
    idle_s();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && (q_w.size() > 0 || q_s.size() > 0); i++) begin
      @(posedge clk);
    end
    #2;
    n_checks++;
    if (q_w.size() > 0 || q_s.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", q_w.size(), q_s.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
